// File: rtl/lms_update_sched_pkg.sv
// Shared types and defaults for the LMS weight-update slice: FSM states, widths,
// the mu step size used by the weight_cal datapath, and a constant clog2 helper.
package lms_pkg;

    localparam int LMS_DW       = 32;
    localparam int LMS_MU_SHIFT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } lms_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/lms_update_sched_if.sv
// Control/data bundle between the filter-level controller (master) and the
// update scheduler (slave), including the buffer and datapath side signals.
interface lms_update_sched_if
    import lms_pkg::*;
#(
    parameter int DW = LMS_DW,
    parameter int AW = 3
);
    logic                 start;
    logic                 abort;
    logic signed [DW-1:0] e_in;
    logic [AW-1:0]        rd_addr;
    logic                 rd_en;
    logic [AW-1:0]        wr_addr;
    logic                 upd_en;
    logic signed [DW-1:0] e_scaled;
    logic                 busy;
    logic                 done;
    logic                 overrun;

    modport master (
        output start, abort, e_in,
        input  rd_addr, rd_en, wr_addr, upd_en, e_scaled, busy, done, overrun
    );

    modport slave (
        input  start, abort, e_in,
        output rd_addr, rd_en, wr_addr, upd_en, e_scaled, busy, done, overrun
    );
endinterface

// File: rtl/lms_lat_pipe.sv
// RD_LAT-deep valid+address delay line that re-times read issues into update
// strobes; a synchronous flush empties every stage at once.
module lms_lat_pipe #(
    parameter int AW     = 3,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_vld,
    input  logic [AW-1:0] in_addr,
    output logic          out_vld,
    output logic [AW-1:0] out_addr
);

    logic [RD_LAT-1:0] vld_p;
    logic [AW-1:0]     addr_p [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_p <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                addr_p[i] <= '0;
            end
        end else begin
            vld_p[0]  <= in_vld;
            addr_p[0] <= in_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i]  <= vld_p[i-1];
                addr_p[i] <= addr_p[i-1];
            end
        end
    end

    assign out_vld  = vld_p[RD_LAT-1];
    assign out_addr = addr_p[RD_LAT-1];

endmodule

// File: rtl/lms_update_sched.sv
// Sequences the shared w <= w + e*x datapath over all taps: latches the mu-scaled
// error, walks read addresses, and re-times them into update strobes.
module lms_update_sched
    import lms_pkg::*;
#(
    parameter int NTAPS    = 8,
    parameter int DW       = LMS_DW,
    parameter int AW       = clog2(NTAPS),
    parameter int RD_LAT   = 1,
    parameter int MU_SHIFT = LMS_MU_SHIFT
) (
    input  logic               clk,
    input  logic               rst,
    lms_update_sched_if.slave  bus
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NTAPS - 1);

    lms_state_e           state_p0, state_nxt;
    logic [AW-1:0]        idx_p0, idx_nxt;
    logic                 pend_p0, pend_nxt;
    logic                 ovr_p0;
    logic signed [DW-1:0] e_scaled_p0;
    logic                 accept, flush, busy;
    logic                 upd_vld;
    logic [AW-1:0]        upd_addr;

    // Arithmetic shift floors negative errors toward -inf (-1 stays -1).
    function automatic logic signed [DW-1:0] mu_scale(input logic signed [DW-1:0] e);
        return e >>> MU_SHIFT;
    endfunction

    always_comb begin
        state_nxt = state_p0;
        idx_nxt   = idx_p0;
        pend_nxt  = pend_p0;
        accept    = 1'b0;
        flush     = 1'b0;
        case (state_p0)
            ST_IDLE: begin
                if (bus.start || pend_p0) begin
                    accept    = 1'b1;
                    pend_nxt  = 1'b0;
                    idx_nxt   = '0;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.abort) begin
                    flush     = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else if (idx_p0 == LAST_IDX) begin
                    idx_nxt   = '0;
                    state_nxt = ST_DRAIN;
                end else begin
                    idx_nxt = idx_p0 + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (bus.abort) begin
                    flush     = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (upd_vld && (upd_addr == LAST_IDX)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                // A start landing on the done pulse is held and taken from IDLE.
                if (bus.abort) begin
                    flush = 1'b1;
                end else if (bus.start) begin
                    pend_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state_p0 == ST_ISSUE) || (state_p0 == ST_DRAIN);

    // Stage p0: control state, error latch and sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0    <= ST_IDLE;
            idx_p0      <= '0;
            pend_p0     <= 1'b0;
            ovr_p0      <= 1'b0;
            e_scaled_p0 <= '0;
        end else begin
            state_p0 <= state_nxt;
            idx_p0   <= idx_nxt;
            pend_p0  <= pend_nxt;
            if (busy && bus.start && !bus.abort) begin
                ovr_p0 <= 1'b1;
            end
            if (accept) begin
                e_scaled_p0 <= mu_scale(bus.e_in);
            end
        end
    end

    // Stage p1..pRD_LAT: read issue re-timed to the datapath update slot.
    lms_lat_pipe #(
        .AW     (AW),
        .RD_LAT (RD_LAT)
    ) u_lat_pipe (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_vld   (bus.rd_en),
        .in_addr  (idx_p0),
        .out_vld  (upd_vld),
        .out_addr (upd_addr)
    );

    assign bus.rd_en    = (state_p0 == ST_ISSUE);
    assign bus.rd_addr  = idx_p0;
    assign bus.upd_en   = upd_vld;
    assign bus.wr_addr  = upd_addr;
    assign bus.e_scaled = e_scaled_p0;
    assign bus.busy     = busy;
    assign bus.done     = (state_p0 == ST_DONE);
    assign bus.overrun  = ovr_p0;

endmodule
